barrett_for_1307: RTL and testbench
===================================

Name: barrett_for_1307

Overview:
- Pipelined Barrett modular reducer. Computes dout_r = din_a mod 1307 for any 21-bit unsigned input.
- Serves as the fixed-prime (p = 1307) reduction stage behind Galois-field multipliers and adders in the systemizer datapath.
- Throughput is one result per clock. Fixed latency. No backpressure.

Parameters:
- P, 1307, modulus (fixed; not user-overridable in this block)
- K, 22, Barrett shift amount (2 x ceil(log2 P))
- MU, 3209, Barrett constant floor(2^K / P)

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  din_a is sampled on this cycle's rising edge when high
- din_a  input  21  unsigned operand, full range 0..2097151
- out_valid  output  1  dout_r holds a valid result this cycle
- dout_r  output  11  din_a mod 1307, range 0..1306

Behaviour:
- Reset: rst_n low asynchronously clears all pipeline registers. out_valid=0 and dout_r=0 while reset is asserted and after release until the first result emerges.
- Reset mid-operation discards every in-flight result. No out_valid pulse comes from data accepted before reset.
- Stage 1 (edge N, in_valid=1):
  - prod = din_a * MU (33-bit unsigned).
  - q_est = prod >> 22 (11 bits; max 1604).
  - Register q_est, din_a, and the valid bit.
- Stage 2 (edge N+1):
  - r0 = a - q_est*1307 (12-bit unsigned; guaranteed 0..2613).
  - If r0 >= 1307, r = r0 - 1307; else r = r0.
  - Register dout_r = r[10:0] and out_valid = valid bit.
- Latency: exactly 2 rising edges from the sampling of din_a to the cycle where out_valid/dout_r present the result.
- Error bound: for a < 2^21, q_est is either floor(a/1307) or floor(a/1307) - 1. A single conditional subtraction is therefore sufficient and mandatory. No second correction stage.
- in_valid=0: a bubble propagates, and out_valid is low 2 cycles later. dout_r holds its previous value during bubbles; it is not cleared.
- Back-to-back in_valid=1 on consecutive cycles yields consecutive results in order, with no gaps.
- Logic is purely unsigned. There is no overflow path; all intermediate widths are sized so that no truncation occurs before the final 11-bit result.
- dout_r must never exceed 1306 when out_valid=1.

Test Plan:
- Reset sweep: assert rst_n low for 3 cycles, release. Check out_valid=0 and dout_r=0 until first valid input plus 2 cycles.
- Identity range: stream din_a = 0..1306 back-to-back. Each result appears 2 cycles later equal to the input, with out_valid continuously high.
- Boundaries:
  - 1307 -> 0
  - 1308 -> 1
  - 1708249 (1307^2) -> 0
  - 1708248 -> 1306
  - 2097151 -> 723
- Correction path: 2096428 (q_est is one short) -> 0; 2096427 -> 1306. Also compare a random sweep of 10k values against a % 1307.
- Bubbles and ordering: pattern in_valid = 1,0,1,1,0 with inputs 5000, x, 65535, 1307, x. Expect out_valid 1,0,1,1,0 shifted by 2 cycles, with dout_r = 1079, 185, 0.
- Reset mid-stream: assert rst_n for one cycle while two inputs are in flight. Neither result emerges, and out_valid stays 0 until new input is accepted.

Source files
------------

// File: rtl/barrett_for_1307.sv
// Two-stage pipelined Barrett reducer: dout_r = din_a mod 1307 for any 21-bit input.
// Stage 1 estimates the quotient; stage 2 subtracts and applies one conditional correction.
module barrett_for_1307 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [20:0] din_a,
  output logic        out_valid,
  output logic [10:0] dout_r
);

  localparam int unsigned P  = 1307;
  localparam int unsigned K  = 22;
  localparam logic [32:0] MU = 33'd3209;

  // Stage 1: quotient estimate, never above floor(a/P) and at most one below it.
  logic [32:0] w_prod;
  logic [10:0] w_q_est;

  assign w_prod  = {12'd0, din_a} * MU;
  assign w_q_est = 11'(w_prod >> K);

  logic        r_v1;
  logic [10:0] r_q;
  logic [20:0] r_a;

  // NOTE: every pipeline register, including the data registers, is cleared on reset
  // so dout_r reads 0 until the first result lands; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_q  <= '0;
      r_a  <= '0;
    end else begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_q <= w_q_est;
        r_a <= din_a;
      end
    end
  end

  // Stage 2: the remainder a - q*P is at most 2P-1, so it fits in 12 bits.
  logic [20:0] w_qp;
  logic [11:0] w_r0;
  logic [11:0] w_r;

  assign w_qp = 21'({10'd0, r_q} * 21'(P));
  assign w_r0 = 12'(r_a - w_qp);
  assign w_r  = (w_r0 >= 12'(P)) ? (w_r0 - 12'(P)) : w_r0;

  // dout_r keeps its last result through bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dout_r    <= '0;
    end else begin
      out_valid <= r_v1;
      if (r_v1) begin
        dout_r <= 11'(w_r);
      end
    end
  end

endmodule

// File: tb/tb_barrett_for_1307.sv
// Directed and random checks for the pipelined mod-1307 Barrett reducer.
// Inputs change 1 time unit after each rising edge; outputs are sampled there too.
module tb_barrett_for_1307;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [20:0] din_a;
  logic        out_valid;
  logic [10:0] dout_r;

  int checks = 0;
  int errors = 0;

  barrett_for_1307 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .din_a     (din_a),
    .out_valid (out_valid),
    .dout_r    (dout_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // After a call, the outputs reflect the input driven on the previous call.
  task automatic cycle(input logic v, input logic [20:0] a);
    in_valid = v;
    din_a    = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din_a    = '0;
    repeat (3) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_valid: got %0d expected 0", out_valid);
      end
      checks++;
      if (dout_r !== 11'd0) begin
        errors++;
        $display("FAIL reset_hold_dout: got %0d expected 0", dout_r);
      end
    end
    rst_n = 1'b1;
    repeat (3) begin
      cycle(1'b0, 21'd0);
      checks++;
      if (out_valid !== 1'b0 || dout_r !== 11'd0) begin
        errors++;
        $display("FAIL post_reset_idle: got valid=%0d dout=%0d expected valid=0 dout=0", out_valid, dout_r);
      end
    end
    cycle(1'b1, 21'd1308);
    checks++;
    if (out_valid !== 1'b0 || dout_r !== 11'd0) begin
      errors++;
      $display("FAIL first_latency_early: got valid=%0d dout=%0d expected valid=0 dout=0", out_valid, dout_r);
    end
    cycle(1'b0, 21'd0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 11'd1) begin
      errors++;
      $display("FAIL first_result: got valid=%0d dout=%0d expected valid=1 dout=1", out_valid, dout_r);
    end
  endtask

  task automatic test_identity();
    for (int i = 0; i <= 1307; i++) begin
      if (i < 1307) cycle(1'b1, 21'(i));
      else          cycle(1'b0, 21'd0);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || dout_r !== 11'(i - 1)) begin
          errors++;
          $display("FAIL identity[%0d]: got valid=%0d dout=%0d expected valid=1 dout=%0d", i - 1, out_valid, dout_r, i - 1);
        end
      end
    end
    cycle(1'b0, 21'd0);
    checks++;
    if (out_valid !== 1'b0 || dout_r !== 11'd1306) begin
      errors++;
      $display("FAIL identity_drain: got valid=%0d dout=%0d expected valid=0 dout=1306", out_valid, dout_r);
    end
  endtask

  task automatic test_boundaries();
    logic [20:0] vin [9];
    logic [10:0] vexp[9];
    vin = '{21'd1307, 21'd1308, 21'd1708249, 21'd1708248, 21'd2097151,
            21'd2096428, 21'd2096427, 21'd1306, 21'd2613};
    vexp = '{11'd0, 11'd1, 11'd0, 11'd1306, 11'd723,
             11'd0, 11'd1306, 11'd1306, 11'd1306};
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) cycle(1'b1, vin[i]);
      else       cycle(1'b0, 21'd0);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || dout_r !== vexp[i-1]) begin
          errors++;
          $display("FAIL boundary_%0d: got valid=%0d dout=%0d expected valid=1 dout=%0d", vin[i-1], out_valid, dout_r, vexp[i-1]);
        end
      end
    end
    cycle(1'b0, 21'd0);
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 21'd4000);
    in_valid = 1'b1;
    din_a    = 21'd5000;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || dout_r !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got valid=%0d dout=%0d expected valid=0 dout=0", out_valid, dout_r);
    end
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (3) begin
      cycle(1'b0, 21'd0);
      checks++;
      if (out_valid !== 1'b0 || dout_r !== 11'd0) begin
        errors++;
        $display("FAIL reset_mid_flush: got valid=%0d dout=%0d expected valid=0 dout=0", out_valid, dout_r);
      end
    end
    cycle(1'b1, 21'd2620);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_early: got valid=%0d expected 0", out_valid);
    end
    cycle(1'b0, 21'd0);
    checks++;
    if (out_valid !== 1'b1 || dout_r !== 11'd6) begin
      errors++;
      $display("FAIL reset_mid_recover: got valid=%0d dout=%0d expected valid=1 dout=6", out_valid, dout_r);
    end
    cycle(1'b0, 21'd0);
  endtask

  task automatic test_bubbles();
    logic        v   [6];
    logic [20:0] a   [6];
    logic        eov [6];
    logic [10:0] edo [6];
    v   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    a   = '{21'd5000, 21'h1FFFFF, 21'd65535, 21'd1307, 21'h0ABCDE, 21'd0};
    eov = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    edo = '{11'd0, 11'd1079, 11'd1079, 11'd185, 11'd0, 11'd0};
    for (int k = 0; k < 6; k++) begin
      cycle(v[k], a[k]);
      if (k > 0) begin
        checks++;
        if (out_valid !== eov[k] || dout_r !== edo[k]) begin
          errors++;
          $display("FAIL bubble_cycle%0d: got valid=%0d dout=%0d expected valid=%0d dout=%0d", k, out_valid, dout_r, eov[k], edo[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [20:0] a;
    logic [10:0] prev_exp;
    prev_exp = '0;
    for (int i = 0; i <= 10000; i++) begin
      a = 21'($urandom_range(0, 2097151));
      if (i < 10000) cycle(1'b1, a);
      else           cycle(1'b0, 21'd0);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || dout_r !== prev_exp || dout_r > 11'd1306) begin
          errors++;
          $display("FAIL random[%0d]: got valid=%0d dout=%0d expected valid=1 dout=%0d", i - 1, out_valid, dout_r, prev_exp);
        end
      end
      prev_exp = 11'(a % 21'd1307);
    end
    cycle(1'b0, 21'd0);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL random_drain: got valid=%0d expected 0", out_valid);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    din_a    = '0;
    test_reset();
    test_identity();
    test_boundaries();
    test_reset_mid();
    test_bubbles();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
